// File: rtl/hv_bundle_acc_if.sv
// Chunk streaming interface between the mapper, the bundling accumulator and the similarity stage.
// The slave modport is the accumulator's view. The master modport is the view of whatever drives it.
interface hv_bundle_acc_if #(
    parameter int CHUNK_W = 16
);
    logic               in_valid;
    logic [3:0]         in_ctr;
    logic [CHUNK_W-1:0] in_chunk;
    logic               out_ready;
    logic               out_valid;
    logic [3:0]         out_ctr;
    logic [CHUNK_W-1:0] out_chunk;

    modport master (
        output in_valid, in_ctr, in_chunk, out_ready,
        input  out_valid, out_ctr, out_chunk
    );

    modport slave (
        input  in_valid, in_ctr, in_chunk, out_ready,
        output out_valid, out_ctr, out_chunk
    );
endinterface

// File: rtl/hv_bundle_acc.sv
// Bundles NUM_FEATURES mapped hypervectors using a per-bit popcount and a majority threshold.
// It then streams the bundled vector out one chunk at a time.
module hv_bundle_acc #(
    parameter int CHUNK_W         = 16,
    parameter int SEQ_CYCLE_COUNT = 16,
    parameter int NUM_FEATURES    = 8
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               en,
    input  logic               start_bundling,
    hv_bundle_acc_if.slave     bus,
    output logic               busy,
    output logic               bundling_done,
    output logic               err_seq
);

    localparam int CNT_W     = $clog2(NUM_FEATURES + 1);
    localparam int THRESHOLD = NUM_FEATURES / 2;

    localparam logic [3:0]       LAST_CHUNK = 4'(SEQ_CYCLE_COUNT - 1);
    localparam logic [CNT_W-1:0] LAST_FEAT  = CNT_W'(NUM_FEATURES - 1);
    localparam logic [CNT_W-1:0] THR        = CNT_W'(THRESHOLD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0]   acc [SEQ_CYCLE_COUNT][CHUNK_W];
    logic [3:0]         exp_ctr;
    logic [3:0]         out_ctr_q;
    logic [CNT_W-1:0]   feat_cnt;
    logic               err_q;
    logic               start_run;
    logic               accept;
    logic               mismatch;
    logic               transfer;
    logic [CHUNK_W-1:0] out_chunk_c;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A chunk that arrives out of order is dropped, so exp_ctr keeps waiting for the resend.
    always_comb begin
        next_state = state;
        start_run  = 1'b0;
        accept     = 1'b0;
        mismatch   = 1'b0;
        transfer   = 1'b0;
        case (state)
            S_IDLE: begin
                if (en && start_bundling) begin
                    start_run  = 1'b1;
                    next_state = S_ACC;
                end
            end
            S_ACC: begin
                if (en && bus.in_valid) begin
                    if (bus.in_ctr == exp_ctr) begin
                        accept = 1'b1;
                        if (exp_ctr == LAST_CHUNK && feat_cnt == LAST_FEAT) begin
                            next_state = S_OUT;
                        end
                    end else begin
                        mismatch = 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (en && bus.out_ready) begin
                    transfer = 1'b1;
                    if (out_ctr_q == LAST_CHUNK) begin
                        next_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (en) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            exp_ctr   <= '0;
            feat_cnt  <= '0;
            err_q     <= 1'b0;
            out_ctr_q <= '0;
        end else begin
            if (start_run) begin
                exp_ctr  <= '0;
                feat_cnt <= '0;
                err_q    <= 1'b0;
            end
            if (accept) begin
                if (exp_ctr == LAST_CHUNK) begin
                    exp_ctr  <= '0;
                    feat_cnt <= feat_cnt + 1'b1;
                end else begin
                    exp_ctr <= exp_ctr + 1'b1;
                end
            end
            if (mismatch) begin
                err_q <= 1'b1;
            end
            if (transfer) begin
                out_ctr_q <= (out_ctr_q == LAST_CHUNK) ? 4'd0 : out_ctr_q + 4'd1;
            end
        end
    end

    // At most NUM_FEATURES ones can land on a bit, so the counters never wrap.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int s = 0; s < SEQ_CYCLE_COUNT; s++) begin
                for (int b = 0; b < CHUNK_W; b++) begin
                    acc[s][b] <= '0;
                end
            end
        end else if (start_run) begin
            for (int s = 0; s < SEQ_CYCLE_COUNT; s++) begin
                for (int b = 0; b < CHUNK_W; b++) begin
                    acc[s][b] <= '0;
                end
            end
        end else if (accept) begin
            for (int b = 0; b < CHUNK_W; b++) begin
                acc[exp_ctr][b] <= acc[exp_ctr][b] + CNT_W'(bus.in_chunk[b]);
            end
        end
    end

    // Strict majority: an exact tie resolves to 0.
    always_comb begin
        out_chunk_c = '0;
        if (state == S_OUT) begin
            for (int b = 0; b < CHUNK_W; b++) begin
                out_chunk_c[b] = (acc[out_ctr_q][b] > THR);
            end
        end
    end

    assign bus.out_valid  = (state == S_OUT);
    assign bus.out_ctr    = out_ctr_q;
    assign bus.out_chunk  = out_chunk_c;
    assign busy           = (state != S_IDLE);
    assign bundling_done  = (state == S_DONE);
    assign err_seq        = err_q;

endmodule

// File: tb/tb_hv_bundle_acc.sv
// Randomised and directed bench for hv_bundle_acc.
// A majority-vote model checks every output chunk.
module tb_hv_bundle_acc;

    localparam int CW  = 16;
    localparam int SEQ = 16;
    localparam int NF  = 8;

    logic clk = 1'b0;
    logic nrst;
    logic en;
    logic start_bundling;
    logic busy;
    logic bundling_done;
    logic err_seq;

    hv_bundle_acc_if #(.CHUNK_W(CW)) bus ();

    hv_bundle_acc #(
        .CHUNK_W(CW),
        .SEQ_CYCLE_COUNT(SEQ),
        .NUM_FEATURES(NF)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .en(en),
        .start_bundling(start_bundling),
        .bus(bus.slave),
        .busy(busy),
        .bundling_done(bundling_done),
        .err_seq(err_seq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [CW-1:0] feat [NF][SEQ];
    int  stall_at;
    int  en_gap_in;
    int  en_gap_out;
    int  err_at;
    bit  start_glitch;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Majority vote per bit position, computed from the raw feature vectors.
    function automatic logic [CW-1:0] golden(input int c);
        logic [CW-1:0] g;
        g = '0;
        for (int b = 0; b < CW; b++) begin
            int ones;
            ones = 0;
            for (int f = 0; f < NF; f++) ones += int'(feat[f][c][b]);
            g[b] = (ones * 2 > NF);
        end
        return g;
    endfunction

    task automatic clear_knobs();
        stall_at     = -1;
        en_gap_in    = -1;
        en_gap_out   = -1;
        err_at       = -1;
        start_glitch = 1'b0;
    endtask

    task automatic apply_stimulus(input string tag);
        for (int f = 0; f < NF; f++) begin
            for (int c = 0; c < SEQ; c++) begin
                int k;
                k = f * SEQ + c;
                if (k == err_at) begin
                    bus.in_valid = 1'b1;
                    bus.in_ctr   = 4'((c + 4) % SEQ);
                    bus.in_chunk = ~feat[f][c];
                    @(negedge clk);
                    check_output({tag, ":err_seq"}, 32'(err_seq), 32'd1);
                end
                if (k == en_gap_in) begin
                    en = 1'b0;
                    bus.in_valid = 1'b1;
                    bus.in_ctr   = 4'(c);
                    bus.in_chunk = feat[f][c];
                    repeat (4) @(negedge clk);
                    check_output({tag, ":en_low_busy"}, 32'(busy), 32'd1);
                    check_output({tag, ":en_low_no_out"}, 32'(bus.out_valid), 32'd0);
                    en = 1'b1;
                end
                if (start_glitch && k == SEQ + 2) start_bundling = 1'b1;
                if (k == NF * SEQ - 1) check_output({tag, ":pre_last_valid"}, 32'(bus.out_valid), 32'd0);
                bus.in_valid = 1'b1;
                bus.in_ctr   = 4'(c);
                bus.in_chunk = feat[f][c];
                @(negedge clk);
                start_bundling = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        check_output({tag, ":latency_valid"}, 32'(bus.out_valid), 32'd1);
        check_output({tag, ":first_ctr"}, 32'(bus.out_ctr), 32'd0);
    endtask

    task automatic collect(input string tag);
        int n;
        int budget;
        bit stalled;
        bit gapped;
        logic [CW-1:0] held;
        n = 0;
        budget = 0;
        stalled = 1'b0;
        gapped = 1'b0;
        bus.out_ready = 1'b1;
        while (n < SEQ && budget < 400) begin
            budget++;
            if (n == stall_at && !stalled) begin
                stalled = 1'b1;
                bus.out_ready = 1'b0;
                held = bus.out_chunk;
                repeat (3) begin
                    @(negedge clk);
                    check_output({tag, ":stall_ctr"}, 32'(bus.out_ctr), 32'(n));
                    check_output({tag, ":stall_chunk"}, 32'(bus.out_chunk), 32'(held));
                end
                bus.out_ready = 1'b1;
            end
            if (n == en_gap_out && !gapped) begin
                gapped = 1'b1;
                en = 1'b0;
                repeat (4) @(negedge clk);
                check_output({tag, ":en_low_out_ctr"}, 32'(bus.out_ctr), 32'(n));
                check_output({tag, ":en_low_out_valid"}, 32'(bus.out_valid), 32'd1);
                en = 1'b1;
            end
            if (bus.out_valid) begin
                check_output({tag, ":out_ctr"}, 32'(bus.out_ctr), 32'(n));
                check_output({tag, ":out_chunk"}, 32'(bus.out_chunk), 32'(golden(n)));
                n++;
            end
            @(negedge clk);
        end
        check_output({tag, ":out_count"}, 32'(n), 32'(SEQ));
        check_output({tag, ":done_pulse"}, 32'(bundling_done), 32'd1);
        check_output({tag, ":done_no_valid"}, 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check_output({tag, ":done_cleared"}, 32'(bundling_done), 32'd0);
        check_output({tag, ":idle"}, 32'(busy), 32'd0);
    endtask

    task automatic run_bundle(input string tag);
        @(negedge clk);
        en = 1'b1;
        start_bundling = 1'b1;
        @(negedge clk);
        start_bundling = 1'b0;
        check_output({tag, ":busy"}, 32'(busy), 32'd1);
        check_output({tag, ":err_clear"}, 32'(err_seq), 32'd0);
        apply_stimulus(tag);
        collect(tag);
    endtask

    initial begin
        nrst = 1'b0;
        en = 1'b1;
        start_bundling = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_ctr = '0;
        bus.in_chunk = '0;
        bus.out_ready = 1'b0;
        clear_knobs();
        repeat (3) @(negedge clk);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_valid", 32'(bus.out_valid), 32'd0);
        check_output("rst_done", 32'(bundling_done), 32'd0);
        check_output("rst_err", 32'(err_seq), 32'd0);
        check_output("rst_chunk", 32'(bus.out_chunk), 32'd0);
        check_output("rst_ctr", 32'(bus.out_ctr), 32'd0);
        nrst = 1'b1;

        for (int f = 0; f < NF; f++) for (int c = 0; c < SEQ; c++) feat[f][c] = (f < 5) ? 16'hFFFF : 16'h0000;
        run_bundle("T1_majority");

        for (int f = 0; f < NF; f++) for (int c = 0; c < SEQ; c++) feat[f][c] = (f < 4) ? 16'hFFFF : 16'h0000;
        run_bundle("T2_tie");

        for (int f = 0; f < NF; f++) for (int c = 0; c < SEQ; c++) feat[f][c] = 16'h1 << ((f + c) % 16);
        run_bundle("T3_sparse");

        for (int f = 0; f < NF; f++) for (int c = 0; c < SEQ; c++) feat[f][c] = (f < 5) ? 16'hA5A5 : 16'h0000;
        run_bundle("T3_a5a5");

        // Random features with output stall, enable gaps and an ignored start pulse.
        for (int f = 0; f < NF; f++) for (int c = 0; c < SEQ; c++) feat[f][c] = 16'($urandom);
        stall_at = 5;
        en_gap_in = 37;
        en_gap_out = 9;
        start_glitch = 1'b1;
        run_bundle("T4_rand_stall");
        clear_knobs();

        for (int f = 0; f < NF; f++) for (int c = 0; c < SEQ; c++) feat[f][c] = 16'($urandom);
        err_at = 3;
        run_bundle("T5_seq_err");
        clear_knobs();

        // Abandon a partial bundle with a reset, then check that a new run is clean.
        @(negedge clk);
        start_bundling = 1'b1;
        @(negedge clk);
        start_bundling = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = 1'b1;
            bus.in_ctr   = 4'(c % SEQ);
            bus.in_chunk = 16'hFFFF;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        nrst = 1'b0;
        #1;
        check_output("T6_rst_busy", 32'(busy), 32'd0);
        check_output("T6_rst_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        for (int f = 0; f < NF; f++) for (int c = 0; c < SEQ; c++) feat[f][c] = 16'($urandom);
        run_bundle("T6_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
